// File: rtl/spislaveio_pkg.sv
// rtl/spislaveio_pkg.sv - register map, bit positions and FSM states for spislaveio
package spislaveio_pkg;

    localparam logic [2:0] REG_DATA   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_CTRL   = 3'd2;

    localparam int ST_RXF   = 0;
    localparam int ST_TXE   = 1;
    localparam int ST_OVR   = 2;
    localparam int ST_SSACT = 3;
    localparam int ST_ABT   = 4;

    localparam int CT_RXIE = 0;
    localparam int CT_TXIE = 1;
    localparam int CT_EN   = 7;

    localparam logic [7:0] FILL_BYTE_DEFAULT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        ABORT = 2'd3
    } spi_state_t;

    function automatic logic [7:0] pack_status(input logic rxf, input logic txe,
                                               input logic ovr, input logic ssact,
                                               input logic abt);
        logic [7:0] s;
        s           = 8'h00;
        s[ST_RXF]   = rxf;
        s[ST_TXE]   = txe;
        s[ST_OVR]   = ovr;
        s[ST_SSACT] = ssact;
        s[ST_ABT]   = abt;
        return s;
    endfunction

endpackage

// File: rtl/spislaveio_spi_sync.sv
// rtl/spislaveio_spi_sync.sv - 2-flop synchronizer with single-cycle rise/fall pulses
module spislaveio_spi_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= RESET_VAL;
            s2   <= RESET_VAL;
            prev <= RESET_VAL;
        end else begin
            s1   <= din;
            s2   <= s1;
            prev <= s2;
        end
    end

    // Pulses are valid for the cycle in which s2 first shows the new level.
    assign sync = s2;
    assign rise = s2 & ~prev;
    assign fall = ~s2 & prev;

endmodule

// File: rtl/spislaveio.sv
// rtl/spislaveio.sv - SPI mode-0 slave with CPU register interface at $E6E0-$E6E7
module spislaveio
    import spislaveio_pkg::*;
#(
    parameter logic [7:0] FILL_BYTE = FILL_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] AD,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    input  logic       rw,
    input  logic       cs,
    output logic       irq,
    input  logic       ssel_n,
    input  logic       sck,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe
);

    spi_state_t state;
    spi_state_t state_nxt;

    logic [7:0] rxbuf;
    logic [7:0] txhold;
    logic [7:0] rxshift;
    logic [7:0] txshift;
    logic [2:0] bitcnt;
    logic       rxf;
    logic       txe;
    logic       ovr;
    logic       abt;
    logic       rxie;
    logic       txie;
    logic       en;
    logic       reload_pend;

    logic ssel_sync, ssel_rise, ssel_fall;
    logic sck_sync, sck_rise, sck_fall;
    logic mosi_s1, mosi_sync;

    logic load_tx, rise_en, fall_en, set_abt, clr_cnt;
    logic reload_fire, byte_done;
    logic data_wr, data_rd, stat_wr, ctrl_wr;
    logic [7:0] tx_next;
    logic [7:0] rx_byte;
    logic unused;

    spislaveio_spi_sync #(.RESET_VAL(1'b1)) u_ssel_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (ssel_n),
        .sync (ssel_sync),
        .rise (ssel_rise),
        .fall (ssel_fall)
    );

    spislaveio_spi_sync #(.RESET_VAL(1'b0)) u_sck_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sck),
        .sync (sck_sync),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    assign unused = &{1'b0, sck_sync};

    // mosi shares the two-stage latency so it lines up with the sck rise pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mosi_s1   <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            mosi_s1   <= mosi;
            mosi_sync <= mosi_s1;
        end
    end

    assign data_wr = cs & ~rw & (AD == REG_DATA);
    assign data_rd = cs &  rw & (AD == REG_DATA);
    assign stat_wr = cs & ~rw & (AD == REG_STATUS);
    assign ctrl_wr = cs & ~rw & (AD == REG_CTRL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_tx   = 1'b0;
        rise_en   = 1'b0;
        fall_en   = 1'b0;
        set_abt   = 1'b0;
        clr_cnt   = 1'b0;
        miso      = 1'b0;
        miso_oe   = 1'b0;
        case (state)
            IDLE: begin
                clr_cnt = 1'b1;
                if (en && ssel_fall) state_nxt = LOAD;
            end
            LOAD: begin
                load_tx   = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                miso    = txshift[7];
                miso_oe = 1'b1;
                if (ssel_rise) begin
                    state_nxt = (bitcnt != 3'd0) ? ABORT : IDLE;
                end else begin
                    rise_en = sck_rise;
                    fall_en = sck_fall;
                end
            end
            ABORT: begin
                set_abt   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Disabling drops the link at once without flagging an abort.
        if (!en) begin
            state_nxt = IDLE;
            load_tx   = 1'b0;
            rise_en   = 1'b0;
            fall_en   = 1'b0;
            set_abt   = 1'b0;
        end
    end

    assign tx_next     = txe ? FILL_BYTE : txhold;
    assign reload_fire = fall_en & reload_pend;
    assign byte_done   = rise_en & (bitcnt == 3'd7);
    assign rx_byte     = {rxshift[6:0], mosi_sync};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxshift     <= 8'h00;
            txshift     <= 8'h00;
            bitcnt      <= 3'd0;
            reload_pend <= 1'b0;
        end else begin
            if (clr_cnt) begin
                bitcnt      <= 3'd0;
                reload_pend <= 1'b0;
            end
            if (rise_en) begin
                rxshift <= rx_byte;
                bitcnt  <= bitcnt + 3'd1;
                if (bitcnt == 3'd7) reload_pend <= 1'b1;
            end
            if (fall_en) begin
                if (reload_pend) begin
                    txshift     <= tx_next;
                    reload_pend <= 1'b0;
                end else if (bitcnt != 3'd0) begin
                    txshift <= {txshift[6:0], 1'b0};
                end
            end
            if (load_tx) txshift <= tx_next;
        end
    end

    // A CPU write beats a same-cycle load: the load used the old value, TXE ends clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txhold <= 8'h00;
            txe    <= 1'b1;
        end else begin
            if (data_wr) txhold <= DI;
            if (data_wr)                       txe <= 1'b0;
            else if (load_tx || reload_fire)   txe <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxbuf <= 8'h00;
            rxf   <= 1'b0;
            ovr   <= 1'b0;
            abt   <= 1'b0;
        end else begin
            if (byte_done) begin
                if (!rxf || data_rd) begin
                    rxbuf <= rx_byte;
                    rxf   <= 1'b1;
                end else begin
                    ovr <= 1'b1;
                end
            end else if (data_rd) begin
                rxf <= 1'b0;
            end
            if (byte_done && rxf && !data_rd)   ovr <= 1'b1;
            else if (stat_wr && DI[ST_OVR])     ovr <= 1'b0;
            if (set_abt)                        abt <= 1'b1;
            else if (stat_wr && DI[ST_ABT])     abt <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxie <= 1'b0;
            txie <= 1'b0;
            en   <= 1'b0;
        end else if (ctrl_wr) begin
            rxie <= DI[CT_RXIE];
            txie <= DI[CT_TXIE];
            en   <= DI[CT_EN];
        end
    end

    always_comb begin
        DO = 8'hFF;
        case (AD)
            REG_DATA:   DO = rxbuf;
            REG_STATUS: DO = pack_status(rxf, txe, ovr, ~ssel_sync, abt);
            REG_CTRL:   DO = {en, 5'b00000, txie, rxie};
            default:    DO = 8'hFF;
        endcase
    end

    assign irq = (rxf & rxie) | (txe & txie);

endmodule

// File: tb/tb_spislaveio.sv
// tb/tb_spislaveio.sv - directed self-checking bench for spislaveio
module tb_spislaveio;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] AD;
    logic [7:0] DI;
    logic [7:0] DO;
    logic       rw;
    logic       cs;
    logic       irq;
    logic       ssel_n;
    logic       sck;
    logic       mosi;
    logic       miso;
    logic       miso_oe;

    int checks = 0;
    int errors = 0;

    spislaveio dut (
        .clk     (clk),
        .rst     (rst),
        .AD      (AD),
        .DI      (DI),
        .DO      (DO),
        .rw      (rw),
        .cs      (cs),
        .irq     (irq),
        .ssel_n  (ssel_n),
        .sck     (sck),
        .mosi    (mosi),
        .miso    (miso),
        .miso_oe (miso_oe)
    );

    always #5 clk = ~clk;

    task automatic cpu_write(input logic [2:0] a, input logic [7:0] d);
        AD = a; DI = d; rw = 1'b0; cs = 1'b1;
        @(negedge clk);
        cs = 1'b0; rw = 1'b1;
    endtask

    task automatic cpu_read(input logic [2:0] a, output logic [7:0] d);
        AD = a; rw = 1'b1; cs = 1'b1;
        #1 d = DO;
        @(negedge clk);
        cs = 1'b0;
    endtask

    task automatic spi_begin();
        ssel_n = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic spi_end();
        repeat (4) @(negedge clk);
        ssel_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Each bit: low phase 4 clk (mosi set), then high phase 4 clk; miso sampled at the rise.
    task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            repeat (4) @(negedge clk);
            rx  = {rx[6:0], miso};
            sck = 1'b1;
            repeat (4) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [7:0] v;
        rst = 1'b1; cs = 1'b0; rw = 1'b1; AD = 3'd0; DI = 8'h00;
        ssel_n = 1'b1; sck = 1'b0; mosi = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        cpu_read(3'd1, v);
        checks++; if (v !== 8'h02) begin errors++; $display("FAIL reset_status got %02h exp 02", v); end
        cpu_read(3'd2, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_ctrl got %02h exp 00", v); end
        cpu_read(3'd0, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_data got %02h exp 00", v); end
        cpu_read(3'd5, v);
        checks++; if (v !== 8'hFF) begin errors++; $display("FAIL reset_unused_reg got %02h exp FF", v); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
        checks++; if (miso_oe !== 1'b0 || miso !== 1'b0) begin
            errors++; $display("FAIL reset_miso got oe=%b miso=%b exp 0 0", miso_oe, miso);
        end
    endtask

    task automatic test_basic();
        logic [7:0] v, r;
        cpu_write(3'd2, 8'h80);
        cpu_write(3'd0, 8'hA5);
        cpu_read(3'd1, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL basic_txe_clear got %02h exp 00", v); end
        spi_begin();
        spi_byte(8'h3C, 8, r);
        spi_end();
        checks++; if (r !== 8'hA5) begin errors++; $display("FAIL basic_master_rx got %02h exp A5", r); end
        cpu_read(3'd1, v);
        checks++; if (v !== 8'h03) begin errors++; $display("FAIL basic_status got %02h exp 03", v); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL basic_irq_masked got %b exp 0", irq); end
        cpu_write(3'd2, 8'h81);
        #1;
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL basic_irq_rxie got %b exp 1", irq); end
        cpu_read(3'd0, v);
        checks++; if (v !== 8'h3C) begin errors++; $display("FAIL basic_rxbuf got %02h exp 3C", v); end
        #1;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL basic_irq_after_read got %b exp 0", irq); end
        cpu_write(3'd2, 8'h82);
        #1;
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL basic_irq_txie got %b exp 1", irq); end
        cpu_read(3'd2, v);
        checks++; if (v !== 8'h82) begin errors++; $display("FAIL basic_ctrl_rb got %02h exp 82", v); end
        cpu_write(3'd2, 8'h80);
    endtask

    task automatic test_overrun();
        logic [7:0] v, r1, r2;
        spi_begin();
        spi_byte(8'h11, 8, r1);
        spi_byte(8'h22, 8, r2);
        spi_end();
        checks++; if (r1 !== 8'hFF) begin errors++; $display("FAIL ovr_fill got %02h exp FF", r1); end
        cpu_read(3'd1, v);
        checks++; if (v !== 8'h07) begin errors++; $display("FAIL ovr_status got %02h exp 07", v); end
        cpu_read(3'd0, v);
        checks++; if (v !== 8'h11) begin errors++; $display("FAIL ovr_rxbuf_kept got %02h exp 11", v); end
        cpu_write(3'd1, 8'h04);
        cpu_read(3'd1, v);
        checks++; if (v !== 8'h02) begin errors++; $display("FAIL ovr_clear got %02h exp 02", v); end
    endtask

    task automatic test_fill_then_write();
        logic [7:0] v, r1, r2;
        spi_begin();
        fork
            spi_byte(8'h00, 8, r1);
            begin
                repeat (20) @(negedge clk);
                cpu_write(3'd0, 8'h5A);
            end
        join
        spi_byte(8'h00, 8, r2);
        spi_end();
        checks++; if (r1 !== 8'hFF) begin errors++; $display("FAIL fill_byte1 got %02h exp FF", r1); end
        checks++; if (r2 !== 8'h5A) begin errors++; $display("FAIL fill_byte2 got %02h exp 5A", r2); end
        cpu_read(3'd1, v);
        checks++; if (v !== 8'h07) begin errors++; $display("FAIL fill_status got %02h exp 07", v); end
        cpu_write(3'd1, 8'h04);
        cpu_read(3'd0, v);
    endtask

    task automatic test_abort();
        logic [7:0] v, r;
        spi_begin();
        cpu_read(3'd1, v);
        checks++; if (v !== 8'h0A) begin errors++; $display("FAIL abort_ssact got %02h exp 0A", v); end
        spi_byte(8'hF0, 5, r);
        spi_end();
        cpu_read(3'd1, v);
        checks++; if (v !== 8'h12) begin errors++; $display("FAIL abort_status got %02h exp 12", v); end
        cpu_write(3'd1, 8'h10);
        cpu_read(3'd1, v);
        checks++; if (v !== 8'h02) begin errors++; $display("FAIL abort_clear got %02h exp 02", v); end
        spi_begin();
        spi_byte(8'h81, 8, r);
        spi_end();
        cpu_read(3'd1, v);
        checks++; if (v !== 8'h03) begin errors++; $display("FAIL abort_next_status got %02h exp 03", v); end
        cpu_read(3'd0, v);
        checks++; if (v !== 8'h81) begin errors++; $display("FAIL abort_next_rx got %02h exp 81", v); end
    endtask

    task automatic test_read_collide();
        logic [7:0] v, r, d_old;
        spi_begin();
        spi_byte(8'h44, 8, r);
        // 8th rise is driven 60 negedges in; its pulse acts on the posedge after negedge 62.
        fork
            spi_byte(8'h99, 8, r);
            begin
                repeat (62) @(negedge clk);
                cpu_read(3'd0, d_old);
            end
        join
        spi_end();
        checks++; if (d_old !== 8'h44) begin errors++; $display("FAIL collide_old got %02h exp 44", d_old); end
        cpu_read(3'd1, v);
        checks++; if (v !== 8'h03) begin errors++; $display("FAIL collide_status got %02h exp 03", v); end
        cpu_read(3'd0, v);
        checks++; if (v !== 8'h99) begin errors++; $display("FAIL collide_rx got %02h exp 99", v); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] v, r;
        cpu_write(3'd2, 8'h81);
        cpu_write(3'd0, 8'h77);
        spi_begin();
        spi_byte(8'hFF, 4, r);
        rst = 1'b1;
        #1;
        checks++; if (miso_oe !== 1'b0 || irq !== 1'b0) begin
            errors++; $display("FAIL midrst_pins got oe=%b irq=%b exp 0 0", miso_oe, irq);
        end
        @(negedge clk);
        cpu_read(3'd1, v);
        checks++; if (v !== 8'h02) begin errors++; $display("FAIL midrst_status got %02h exp 02", v); end
        cpu_read(3'd2, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL midrst_ctrl got %02h exp 00", v); end
        rst = 1'b0;
        ssel_n = 1'b1;
        repeat (6) @(negedge clk);
        cpu_write(3'd2, 8'h80);
        cpu_write(3'd0, 8'hC3);
        spi_begin();
        spi_byte(8'h5E, 8, r);
        spi_end();
        checks++; if (r !== 8'hC3) begin errors++; $display("FAIL midrst_next_tx got %02h exp C3", r); end
        cpu_read(3'd0, v);
        checks++; if (v !== 8'h5E) begin errors++; $display("FAIL midrst_next_rx got %02h exp 5E", v); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_fill_then_write();
        test_abort();
        test_read_collide();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
